sram_wr_arb: RTL
================

// Module: sram_wr_arb
// PURPOSE
//  Packet-level round-robin scheduler that shares the single SRAM write port of sram_ctrl among
//  NUM_PORTS ingress ports. Grants one port for a whole packet, forwards its 16-bit words as
//  en_a/data_ina/port_ina/wr_eop, inserts the idle gap sram_ctrl needs between packets, and holds
//  off new grants while the free-page count (cnt_em) is below a threshold.
// PARAMETERS
//  NUM_PORTS  16    ingress ports; port index width PW = $clog2(NUM_PORTS) = 4
//  DATA_W     16    word width, matches data_ina
//  MIN_FREE   2     minimum cnt_em (free pages) required to start a new grant
//  MAX_WORDS  1024  longest legal packet in words; longer packets are truncated
//  TIMEOUT    64    idle cycles of granted port mid-packet before abort
// PORTS
//  sys_clk    in   1                    clock, all logic on rising edge
//  sys_rst_n  in   1                    asynchronous active-low reset
//  req        in   NUM_PORTS            per-port packet pending (level)
//  vld        in   NUM_PORTS            per-port word valid
//  eop        in   NUM_PORTS            per-port last word of packet, qualified by vld
//  data_in    in   NUM_PORTS*DATA_W     per-port word, port p at [p*DATA_W +: DATA_W]
//  cnt_em     in   12                   free pages reported by sram_ctrl
//  gnt        out  NUM_PORTS            one-hot grant; port may drive vld only while its bit is set
//  en_a       out  1                    SRAM write enable to sram_ctrl
//  data_ina   out  DATA_W               forwarded word
//  port_ina   out  4                    granted port index
//  wr_eop     out  1                    last word of packet, coincident with en_a
//  busy       out  1                    state != IDLE
//  err_trunc  out  1                    1-cycle pulse: packet truncated at MAX_WORDS
//  err_tmo    out  1                    1-cycle pulse: packet aborted by timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, word/idle counters 0. Reset mid-packet drops it.
//  FSM IDLE -> GRANT -> XFER -> GAP -> IDLE.
//   IDLE: if |req && cnt_em >= MIN_FREE, pick first requesting port at or after rr pointer
//     (wrapping NUM_PORTS-1 -> 0); latch sel, go GRANT. Else stay.
//   GRANT (1 cycle): gnt <= 1<<sel, port_ina <= sel, word counter cleared; go XFER.
//   XFER: each cycle vld[sel]=1: en_a<=1, data_ina<=word, wr_eop<=eop[sel] (registered, latency 1).
//     vld[sel]=0: en_a<=0, idle counter++; vld/eop/req of non-granted ports ignored.
//     eop[sel]&vld[sel]: gnt<=0 same edge, go GAP.
//     Word MAX_WORDS accepted without eop: forced wr_eop=1 on it, err_trunc pulse, gnt<=0, GAP.
//     Idle counter == TIMEOUT: gnt<=0, en_a=0, err_tmo pulse, go GAP (no wr_eop emitted).
//   GAP (1 cycle): en_a=0, wr_eop=0; rr pointer <= sel+1 mod NUM_PORTS; go IDLE.
//  Min spacing: >=2 cycles of en_a=0 between last word of one packet and first of next.
//  cnt_em is sampled only in IDLE; dropping below MIN_FREE mid-packet does not preempt.
//  req[sel] deasserting mid-packet is ignored; packet ends only via eop, truncation or timeout.
//  port_ina stable from GRANT through GAP; data_ina holds last value when en_a=0.
//  gnt deasserts on the edge the last word is captured; word presented by the port after that
//  edge is not consumed.
// TESTING
//  T1 req=0x0001, 3 words eop on 3rd, cnt_em=100 -> gnt=0x0001, en_a 3 cycles, wr_eop on word 3,
//     port_ina=0.
//  T2 req=0xFFFF held, 1-word packets -> grant order 0,1,...,15,0; rr wraps after port 15.
//  T3 req=0x0010, cnt_em=1 -> no grant, busy=0; cnt_em->2 -> gnt=0x0010 within 2 cycles.
//  T4 port 5 sends 1025 words no eop -> wr_eop on word 1024, err_trunc 1 pulse, word 1025 unforwarded.
//  T5 port 3 stalls (vld=0) 64 cycles mid-packet -> err_tmo pulse, gnt=0, IDLE; port 4 next.
//  T6 assert sys_rst_n=0 mid-XFER -> all outputs 0 asynchronously; first grant after reset to port 0.

Source files
------------

// File: rtl/sram_wr_arb.sv
// Packet-level round-robin arbiter for the single sram_ctrl write port; words forwarded with 1-cycle latency.
// Ports see no backpressure beyond gnt: a port may present words only while its grant bit is set.
module sram_wr_arb #(
   parameter int  NUM_PORTS = 16,
   parameter int  DATA_W    = 16,
   parameter int  MIN_FREE  = 2,
   parameter int  MAX_WORDS = 1024,
   parameter int  TIMEOUT   = 64,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS-1:0]        vld,
   input  logic [NUM_PORTS-1:0]        eop,
   input  logic [NUM_PORTS*DATA_W-1:0] data_in,
   input  logic [11:0]                 cnt_em,
   output logic [NUM_PORTS-1:0]        gnt,
   output logic                        en_a,
   output logic [DATA_W-1:0]           data_ina,
   output logic [PW-1:0]               port_ina,
   output logic                        wr_eop,
   output logic                        busy,
   output logic                        err_trunc,
   output logic                        err_tmo
);

   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        sel_q, sel_d, rr_q, rr_d, pick;
   logic                 found;
   logic [WCW-1:0]       word_q, word_d;
   logic [TCW-1:0]       idle_q, idle_d;
   logic [NUM_PORTS-1:0] gnt_q, gnt_d;
   logic                 en_a_q, en_a_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [PW-1:0]        port_q, port_d;
   logic                 eop_q, eop_d;
   logic                 trunc_q, trunc_d;
   logic                 tmo_q, tmo_d;
   logic [DATA_W-1:0]    word_in;

   assign word_in = data_in[int'(sel_q)*DATA_W +: DATA_W];

   // First requester at or after the rr pointer, wrapping past the last port.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req[(int'(rr_q) + i) % NUM_PORTS]) begin
            found = 1'b1;
            pick  = PW'((int'(rr_q) + i) % NUM_PORTS);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      word_d  = word_q;
      idle_d  = idle_q;
      gnt_d   = gnt_q;
      en_a_d  = 1'b0;
      data_d  = data_q;
      port_d  = port_q;
      eop_d   = 1'b0;
      trunc_d = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found && cnt_em >= 12'(MIN_FREE)) begin
               sel_d   = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            gnt_d        = '0;
            gnt_d[sel_q] = 1'b1;
            port_d       = sel_q;
            word_d       = '0;
            idle_d       = '0;
            state_d      = XFER;
         end
         XFER: begin
            if (vld[sel_q]) begin
               en_a_d = 1'b1;
               data_d = word_in;
               idle_d = '0;
               word_d = word_q + WCW'(1);
               if (eop[sel_q]) begin
                  eop_d   = 1'b1;
                  gnt_d   = '0;
                  state_d = GAP;
               end else if (word_q == WCW'(MAX_WORDS - 1)) begin
                  eop_d   = 1'b1;
                  trunc_d = 1'b1;
                  gnt_d   = '0;
                  state_d = GAP;
               end
            end else begin
               idle_d = idle_q + TCW'(1);
               if (idle_q == TCW'(TIMEOUT - 1)) begin
                  tmo_d   = 1'b1;
                  gnt_d   = '0;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            rr_d    = (sel_q == PW'(NUM_PORTS - 1)) ? '0 : sel_q + PW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
         word_q  <= '0;
         idle_q  <= '0;
         gnt_q   <= '0;
         en_a_q  <= 1'b0;
         data_q  <= '0;
         port_q  <= '0;
         eop_q   <= 1'b0;
         trunc_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         word_q  <= word_d;
         idle_q  <= idle_d;
         gnt_q   <= gnt_d;
         en_a_q  <= en_a_d;
         data_q  <= data_d;
         port_q  <= port_d;
         eop_q   <= eop_d;
         trunc_q <= trunc_d;
         tmo_q   <= tmo_d;
      end
   end

   assign gnt       = gnt_q;
   assign en_a      = en_a_q;
   assign data_ina  = data_q;
   assign port_ina  = port_q;
   assign wr_eop    = eop_q;
   assign busy      = (state_q != IDLE);
   assign err_trunc = trunc_q;
   assign err_tmo   = tmo_q;

endmodule
